// File: rtl/aib_tx_bert_mgen.sv
// TX BERT pattern source: NUM_GEN PRBS/fixed generators with burst control,
// a per-lane generator crossbar and single-cycle error injection.
module aib_tx_bert_mgen #(
  parameter  int NUM_GEN   = 4,
  parameter  int NUM_LANES = 40,
  localparam int GSW       = $clog2(NUM_GEN),
  localparam int LW        = $clog2(NUM_LANES)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_GEN-1:0]       tx_start_pulse,
  input  logic [NUM_GEN-1:0]       tx_rst_pulse,
  input  logic [3*NUM_GEN-1:0]     tx_ptrn_sel,
  input  logic [NUM_GEN-1:0]       tx_seed_ld,
  input  logic [31:0]              txwdata_sync_ff,
  input  logic [15:0]              tx_burst_len,
  input  logic [1:0]               tx_sft_nb,
  input  logic [GSW*NUM_LANES-1:0] lane_gen_sel,
  input  logic                     err_inj_pulse,
  input  logic [LW-1:0]            err_inj_lane,
  output logic [NUM_GEN-1:0]       tx_seed_good,
  output logic [NUM_GEN-1:0]       tx_bertgen_en,
  output logic [NUM_GEN-1:0]       tx_bert_done,
  output logic [15:0]              err_inj_cnt,
  output logic [8*NUM_LANES-1:0]   tx_bert_data_out
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} st_e;

  st_e         state_q [NUM_GEN];
  st_e         state_d [NUM_GEN];
  logic [31:0] seed_q  [NUM_GEN];
  logic [31:0] seed_d  [NUM_GEN];
  logic [31:0] work_q  [NUM_GEN];
  logic [31:0] work_d  [NUM_GEN];
  logic [7:0]  hist_q  [NUM_GEN];
  logic [7:0]  hist_d  [NUM_GEN];
  logic [15:0] cnt_q   [NUM_GEN];
  logic [15:0] cnt_d   [NUM_GEN];

  logic [8*NUM_LANES-1:0] xbar_s;
  logic [8*NUM_LANES-1:0] inj_mask_s;
  logic [8*NUM_LANES-1:0] data_q;
  logic [15:0]            inj_cnt_q;
  logic                   inj_hit_s;

  logic [2:0]     sel_s;
  logic [31:0]    w_s;
  logic [7:0]     h_s;
  logic [32:0]    r_s;
  logic [3:0]     nsteps_s;
  logic [GSW-1:0] gsel_s;
  logic           lane_run_s;

  function automatic logic [31:0] pat_mask(input logic [2:0] sel);
    logic [31:0] m;
    case (sel)
      3'd1:    m = 32'h0000_7FFF;
      3'd2:    m = 32'h007F_FFFF;
      3'd3:    m = 32'h7FFF_FFFF;
      3'd4:    m = 32'hFFFF_FFFF;
      default: m = 32'h0000_007F;
    endcase
    return m;
  endfunction

  // One LFSR/rotate step: {produced bit, next working state}.
  function automatic logic [32:0] lfsr_step(input logic [31:0] w, input logic [2:0] sel);
    logic nb;
    case (sel)
      3'd1:    nb = w[14] ^ w[13];
      3'd2:    nb = w[22] ^ w[17];
      3'd3:    nb = w[30] ^ w[27];
      3'd4:    nb = w[31];
      default: nb = w[6] ^ w[5];
    endcase
    return {nb, ({w[30:0], nb} & pat_mask(sel))};
  endfunction

  assign nsteps_s = 4'd1 << tx_sft_nb;

  // Per-generator next state: seed, working state, history and burst counter.
  always_comb begin
    sel_s = 3'd0;
    w_s   = 32'd0;
    h_s   = 8'd0;
    r_s   = 33'd0;
    for (int g = 0; g < NUM_GEN; g++) begin
      sel_s           = tx_ptrn_sel[3*g +: 3];
      tx_seed_good[g] = |(seed_q[g] & pat_mask(sel_s));
      tx_bertgen_en[g] = (state_q[g] == ST_RUN);
      tx_bert_done[g]  = (state_q[g] == ST_DONE);
      state_d[g] = state_q[g];
      seed_d[g]  = seed_q[g];
      work_d[g]  = work_q[g];
      hist_d[g]  = hist_q[g];
      cnt_d[g]   = cnt_q[g];
      if (tx_rst_pulse[g]) begin
        state_d[g] = ST_IDLE;
        hist_d[g]  = 8'd0;
        cnt_d[g]   = 16'd0;
      end else begin
        case (state_q[g])
          ST_RUN: begin
            w_s = work_q[g];
            h_s = hist_q[g];
            for (int k = 0; k < 8; k++) begin
              if (k[3:0] < nsteps_s) begin
                r_s = lfsr_step(w_s, sel_s);
                w_s = r_s[31:0];
                h_s = {h_s[6:0], r_s[32]};
              end else begin
                r_s = r_s;
              end
            end
            work_d[g] = w_s;
            hist_d[g] = h_s;
            // A zero counter means an unlimited burst.
            if (cnt_q[g] != 16'd0) begin
              cnt_d[g] = cnt_q[g] - 16'd1;
              if (cnt_q[g] == 16'd1) begin
                state_d[g] = ST_DONE;
              end else begin
                state_d[g] = ST_RUN;
              end
            end else begin
              cnt_d[g] = 16'd0;
            end
          end
          default: begin
            if (tx_seed_ld[g]) begin
              seed_d[g] = txwdata_sync_ff;
            end else if (tx_start_pulse[g] && tx_seed_good[g]) begin
              state_d[g] = ST_RUN;
              work_d[g]  = seed_q[g];
              cnt_d[g]   = tx_burst_len;
            end else begin
              state_d[g] = state_q[g];
            end
          end
        endcase
      end
    end
  end

  // Lane crossbar and injection mask for the next output word.
  always_comb begin
    xbar_s     = '0;
    inj_mask_s = '0;
    gsel_s     = '0;
    lane_run_s = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      gsel_s = lane_gen_sel[GSW*l +: GSW];
      if (int'(gsel_s) < NUM_GEN) begin
        xbar_s[8*l +: 8] = hist_q[gsel_s];
        lane_run_s       = (state_q[gsel_s] == ST_RUN);
      end else begin
        xbar_s[8*l +: 8] = 8'h00;
        lane_run_s       = 1'b0;
      end
      if (err_inj_pulse && (int'(err_inj_lane) == l) && lane_run_s) begin
        inj_mask_s[8*l] = 1'b1;
      end else begin
        inj_mask_s[8*l] = 1'b0;
      end
    end
    inj_hit_s = |inj_mask_s;
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int g = 0; g < NUM_GEN; g++) begin
        state_q[g] <= ST_IDLE;
        seed_q[g]  <= 32'd0;
        work_q[g]  <= 32'd0;
        hist_q[g]  <= 8'd0;
        cnt_q[g]   <= 16'd0;
      end
    end else begin
      for (int g = 0; g < NUM_GEN; g++) begin
        state_q[g] <= state_d[g];
        seed_q[g]  <= seed_d[g];
        work_q[g]  <= work_d[g];
        hist_q[g]  <= hist_d[g];
        cnt_q[g]   <= cnt_d[g];
      end
    end
  end

  // Registered output word and saturating injection counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      inj_cnt_q <= 16'd0;
    end else begin
      data_q <= xbar_s ^ inj_mask_s;
      if (inj_hit_s && (inj_cnt_q != 16'hFFFF)) begin
        inj_cnt_q <= inj_cnt_q + 16'd1;
      end else begin
        inj_cnt_q <= inj_cnt_q;
      end
    end
  end

  assign tx_bert_data_out = data_q;
  assign err_inj_cnt      = inj_cnt_q;

endmodule
